// File: rtl/shiftreg_pkg.sv
// -----------------------------------------------------------------------------
// shiftreg_pkg
// Shared constants and types for the serial shift register block.
//   SHIFTREG_DEFAULT_DEPTH : default number of 1-bit stages
//   SHIFTREG_MAX_DEPTH     : largest supported stage count
//   SHIFTREG_RST_VAL       : default per-stage reset value
//   shiftreg_vec_t         : vector wide enough for any legal stage count
//   shiftreg_fill()        : helper returning DEPTH copies of a bit
// -----------------------------------------------------------------------------
package shiftreg_pkg;

    localparam int   SHIFTREG_DEFAULT_DEPTH = 4;
    localparam int   SHIFTREG_MAX_DEPTH     = 64;
    localparam logic SHIFTREG_RST_VAL       = 1'b0;

    typedef logic [SHIFTREG_MAX_DEPTH-1:0] shiftreg_vec_t;

    // Replicates v into the low 'depth' bits; upper bits are zero.
    function automatic shiftreg_vec_t shiftreg_fill(input logic v, input int depth);
        shiftreg_vec_t r_vec;
        r_vec = '0;
        for (int k = 0; k < SHIFTREG_MAX_DEPTH; k++) begin
            if (k < depth) begin
                r_vec[k] = v;
            end
        end
        return r_vec;
    endfunction

endpackage : shiftreg_pkg

// File: rtl/shiftreg_stage.sv
// -----------------------------------------------------------------------------
// shiftreg_stage
// One storage bit of the shift register: a D flip-flop with asynchronous,
// active-low clear to a parameterised value.
//   clk : clock, captures i_d on the rising edge
//   clr : asynchronous active-low clear, forces o_q to RST_VAL
//   i_d : data in
//   o_q : registered data out
// -----------------------------------------------------------------------------
module shiftreg_stage
    import shiftreg_pkg::*;
#(
    parameter logic RST_VAL = SHIFTREG_RST_VAL
) (
    input  logic clk,
    input  logic clr,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : shiftreg_stage

// File: rtl/shiftreg_4bit.sv
// -----------------------------------------------------------------------------
// shiftreg_4bit
// Serial-in / serial-out delay line of DEPTH 1-bit stages. Every rising clock
// edge shifts; the serial output is the last stage with no extra register.
//   clk : clock
//   clr : asynchronous active-low clear, all stages to RST_VAL
//   in  : serial data in, sampled on each rising edge
//   out : serial data out, copy of stage DEPTH-1
//   q   : (only with SHIFTREG_4BIT_PAR_OUT_EN) parallel view, q[k] = stage k
// Parameters: DEPTH (1..64), RST_VAL.
// Optional feature macro: SHIFTREG_4BIT_PAR_OUT_EN adds the q port.
// -----------------------------------------------------------------------------
module shiftreg_4bit
    import shiftreg_pkg::*;
#(
    parameter int   DEPTH   = SHIFTREG_DEFAULT_DEPTH,
    parameter logic RST_VAL = SHIFTREG_RST_VAL
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in,
    output logic             out
`ifdef SHIFTREG_4BIT_PAR_OUT_EN
    ,
    output logic [DEPTH-1:0] q
`endif
);

    // Stage outputs, stage 0 is the newest sample.
    logic [DEPTH-1:0] w_stage;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic w_d;

            // Stage 0 takes the serial input, every later stage its predecessor.
            if (gi == 0) begin : g_head
                assign w_d = in;
            end else begin : g_chain
                assign w_d = w_stage[gi-1];
            end

            shiftreg_stage #(
                .RST_VAL (RST_VAL)
            ) u_stage (
                .clk (clk),
                .clr (clr),
                .i_d (w_d),
                .o_q (w_stage[gi])
            );
        end
    endgenerate

    assign out = w_stage[DEPTH-1];

`ifdef SHIFTREG_4BIT_PAR_OUT_EN
    assign q = w_stage;
`endif

endmodule : shiftreg_4bit

// File: tb/tb_shiftreg_4bit.sv
// -----------------------------------------------------------------------------
// tb_shiftreg_4bit
// Self-checking bench for shiftreg_4bit (DEPTH=4). A history queue of sampled
// bits predicts every stage; directed literal checks pin the expected timing.
// Define SHIFTREG_4BIT_PAR_OUT_EN to also exercise the parallel output q.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shiftreg_4bit;

    localparam int   DEPTH   = 4;
    localparam logic RST_VAL = 1'b0;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic in  = 1'b0;
    logic out;
`ifdef SHIFTREG_4BIT_PAR_OUT_EN
    logic [DEPTH-1:0] q;
`endif

    int  total = 0;
    int  bad   = 0;
    bit  check_en = 1'b0;

    // hist[0] is the most recent bit shifted in since the last reset.
    logic hist[$];

    always #5 clk = ~clk;

    shiftreg_4bit #(
        .DEPTH   (DEPTH),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk (clk),
        .clr (clr),
        .in  (in),
        .out (out)
`ifdef SHIFTREG_4BIT_PAR_OUT_EN
        ,
        .q   (q)
`endif
    );

    // ---------------- reference model ----------------
    always @(posedge clk) begin
        if (clr) begin
            hist.push_front(in);
            if (hist.size() > 64) begin
                void'(hist.pop_back());
            end
        end
    end

    always @(negedge clr) begin
        hist.delete();
    end

    function automatic logic model_stage(input int k);
        if (k < hist.size()) begin
            return hist[k];
        end
        return RST_VAL;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end else begin
            $display("ok   %s t=%0t value=%0h", name, $time, act);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("model_out", {63'd0, out}, {63'd0, model_stage(DEPTH-1)});
`ifdef SHIFTREG_4BIT_PAR_OUT_EN
            begin
                logic [DEPTH-1:0] exp_q;
                for (int k = 0; k < DEPTH; k++) begin
                    exp_q[k] = model_stage(k);
                end
                chk("model_q", {60'd0, q}, {60'd0, exp_q});
            end
`endif
        end
    end

    // Pulse clr low between clock edges; leaves time 1ns before the next edge.
    task automatic reset_mid();
        @(negedge clk);
        #2 clr = 1'b0;
        #1 chk("async_clr", {63'd0, out}, 64'd0);
        #1 clr = 1'b1;
    endtask

    // ---------------- directed stimulus ----------------
    logic pat [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                       1'b1, 1'b1, 1'b1, 1'b1};
    logic lit [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                       1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        // Reset from t=2 to t=7; the edge at t=5 must not shift.
        #2 clr = 1'b0;
        check_en = 1'b1;
        #1 chk("rst_out", {63'd0, out}, 64'd0);
`ifdef SHIFTREG_4BIT_PAR_OUT_EN
        chk("rst_q", {60'd0, q}, 64'd0);
`endif
        #4 clr = 1'b1;

        // Pattern driven before edges 15..85, then held at 1.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("pattern", {63'd0, out}, {63'd0, lit[i]});
            in = pat[i];
        end

        // Single pulse sampled on the first edge after reset release.
        reset_mid();
        in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("latency", {63'd0, out}, {63'd0, (k == 4)});
            in = 1'b0;
        end

        // Fill with ones, clear mid-stream, then a constant-1 stream.
        in = 1'b1;
        repeat (4) @(negedge clk);
        chk("load_ones", {63'd0, out}, 64'd1);
        reset_mid();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("const_stream", {63'd0, out}, {63'd0, (k >= 4)});
        end

`ifdef SHIFTREG_4BIT_PAR_OUT_EN
        // Sample 1,0,1,1: q[0] holds the last bit.
        reset_mid();
        in = 1'b1;
        @(negedge clk); in = 1'b0;
        @(negedge clk); in = 1'b1;
        @(negedge clk); in = 1'b1;
        @(negedge clk);
        chk("par_q", {60'd0, q}, 64'hD);
        chk("par_out", {63'd0, out}, 64'd1);
`endif

        @(negedge clk);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_shiftreg_4bit
